// File: rtl/sub_arbiter.sv
// sub_arbiter: two requesters share one 16-bit ripple subtractor through a
// round-robin arbiter and a two-stage valid/ready pipeline.

// RippleSubtractor16: the shared 16-bit ripple subtractor, S = A - B, with
// signed positive (Op) and negative (On) overflow flags.
module RippleSubtractor16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] S,
    output logic        Op,
    output logic        On
);

    // Ripple A + ~B + 1 from LSB to MSB, one full adder per bit
    always_comb begin
        logic w_carry;
        w_carry = 1'b1;
        S       = 16'd0;
        for (int i = 0; i < 16; i++) begin
            S[i]    = A[i] ^ ~B[i] ^ w_carry;
            w_carry = (A[i] & ~B[i]) | (w_carry & (A[i] ^ ~B[i]));
        end
    end

    // Overflow happens only when the operand signs differ and the result sign
    // disagrees with A: positive minus negative or negative minus positive
    always_comb begin
        Op = ~A[15] &  B[15] &  S[15];
        On =  A[15] & ~B[15] & ~S[15];
    end

endmodule

module sub_arbiter #(
    parameter int SAT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic signed [15:0] req0_a,
    input  logic signed [15:0] req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic signed [15:0] req1_a,
    input  logic signed [15:0] req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic signed [15:0] rsp_data,
    output logic               rsp_id,
    output logic               rsp_op,
    output logic               rsp_on,
    output logic               busy,
    output logic [7:0]         ovf_cnt
);

    logic               r_aValid;
    logic signed [15:0] r_aA;
    logic signed [15:0] r_aB;
    logic               r_aId;

    logic               r_bValid;
    logic signed [15:0] r_bData;
    logic               r_bId;
    logic               r_bOp;
    logic               r_bOn;

    logic               r_lastGrant;
    logic [7:0]         r_ovfCnt;

    logic [15:0]        w_subS;
    logic               w_subOp;
    logic               w_subOn;
    logic [15:0]        w_resData;
    logic               w_drain;
    logic               w_aAdvance;
    logic               w_aCanAccept;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_accept0;
    logic               w_accept1;

    RippleSubtractor16 u_sub (
        .A  (r_aA),
        .B  (r_aB),
        .S  (w_subS),
        .Op (w_subOp),
        .On (w_subOn)
    );

    // Pipeline flow control: B drains on a response handshake, A moves into B
    // whenever B is empty or draining, and A takes a new pair when it frees up
    always_comb begin
        w_drain      = r_bValid & rsp_ready;
        w_aAdvance   = r_aValid & (~r_bValid | rsp_ready);
        w_aCanAccept = ~r_aValid | w_aAdvance;
    end

    // Round-robin grant: a lone requester always wins, on a tie the one that
    // was not granted last wins (r_lastGrant=1 means requester 1 went last)
    always_comb begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant0 = r_lastGrant;
            w_grant1 = ~r_lastGrant;
        end
    end

    // Readies are forced low during reset; grants imply valid so at most one
    // ready is ever high and the accept terms follow directly
    always_comb begin
        req0_ready = w_aCanAccept & w_grant0 & ~rst;
        req1_ready = w_aCanAccept & w_grant1 & ~rst;
        w_accept0  = req0_ready & req0_valid;
        w_accept1  = req1_ready & req1_valid;
    end

    // Saturating mode replaces overflowed differences with the nearest limit;
    // the flags themselves pass through untouched in both modes
    always_comb begin
        w_resData = w_subS;
        if (SAT != 0) begin
            if (w_subOp) begin
                w_resData = 16'h7FFF;
            end else if (w_subOn) begin
                w_resData = 16'h8000;
            end
        end
    end

    // Stage A captures the granted operand pair only on its acceptance edge,
    // and the last-grant pointer moves only when something is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aValid    <= 1'b0;
            r_aA        <= 16'sd0;
            r_aB        <= 16'sd0;
            r_aId       <= 1'b0;
            r_lastGrant <= 1'b1;
        end else begin
            if (w_accept0 || w_accept1) begin
                r_aValid    <= 1'b1;
                r_aA        <= w_accept1 ? req1_a : req0_a;
                r_aB        <= w_accept1 ? req1_b : req0_b;
                r_aId       <= w_accept1;
                r_lastGrant <= w_accept1;
            end else if (w_aAdvance) begin
                r_aValid <= 1'b0;
            end
        end
    end

    // Stage B registers the subtractor result of stage A and holds it
    // unchanged while the response is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bValid <= 1'b0;
            r_bData  <= 16'sd0;
            r_bId    <= 1'b0;
            r_bOp    <= 1'b0;
            r_bOn    <= 1'b0;
        end else begin
            if (w_aAdvance) begin
                r_bValid <= 1'b1;
                r_bData  <= w_resData;
                r_bId    <= r_aId;
                r_bOp    <= w_subOp;
                r_bOn    <= w_subOn;
            end else if (w_drain) begin
                r_bValid <= 1'b0;
            end
        end
    end

    // Count consumed responses that carried an overflow flag, sticking at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovfCnt <= 8'd0;
        end else if (w_drain && (r_bOp || r_bOn) && (r_ovfCnt != 8'hFF)) begin
            r_ovfCnt <= r_ovfCnt + 8'd1;
        end
    end

    assign rsp_valid = r_bValid;
    assign rsp_data  = r_bData;
    assign rsp_id    = r_bId;
    assign rsp_op    = r_bOp;
    assign rsp_on    = r_bOn;
    assign busy      = r_aValid | r_bValid;
    assign ovf_cnt   = r_ovfCnt;

endmodule

// File: tb/tb_sub_arbiter.sv
// tb_sub_arbiter: drives one SAT=0 and one SAT=1 instance with the same
// stimulus and checks both against a transaction-level model of the arbiter.
module tb_sub_arbiter;

    localparam logic [15:0] Z = 16'd0;

    logic        clk;
    logic        rst;
    logic        req0Valid;
    logic        req1Valid;
    logic        rspReady;
    logic [15:0] req0A;
    logic [15:0] req0B;
    logic [15:0] req1A;
    logic [15:0] req1B;

    logic        d0Ready0, d0Ready1, d0RspValid, d0RspId, d0RspOp, d0RspOn, d0Busy;
    logic [15:0] d0RspData;
    logic [7:0]  d0Ovf;
    logic        d1Ready0, d1Ready1, d1RspValid, d1RspId, d1RspOp, d1RspOn, d1Busy;
    logic [15:0] d1RspData;
    logic [7:0]  d1Ovf;

    int checks = 0;
    int errors = 0;
    bit modelOn = 1'b0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        id;
        logic        inB;
    } entry_t;

    typedef struct {
        logic        r0;
        logic        r1;
        logic        v;
        logic        busy;
        logic [7:0]  ovf;
        logic [15:0] dWrap;
        logic [15:0] dSat;
        logic        id;
        logic        op;
        logic        on;
    } pred_t;

    entry_t mq[$];
    logic   lastGrant = 1'b1;
    int     ovfModel  = 0;

    sub_arbiter #(.SAT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req0_valid(req0Valid), .req0_ready(d0Ready0), .req0_a(req0A), .req0_b(req0B),
        .req1_valid(req1Valid), .req1_ready(d0Ready1), .req1_a(req1A), .req1_b(req1B),
        .rsp_valid(d0RspValid), .rsp_ready(rspReady), .rsp_data(d0RspData),
        .rsp_id(d0RspId), .rsp_op(d0RspOp), .rsp_on(d0RspOn),
        .busy(d0Busy), .ovf_cnt(d0Ovf)
    );

    sub_arbiter #(.SAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0Valid), .req0_ready(d1Ready0), .req0_a(req0A), .req0_b(req0B),
        .req1_valid(req1Valid), .req1_ready(d1Ready1), .req1_a(req1A), .req1_b(req1B),
        .rsp_valid(d1RspValid), .rsp_ready(rspReady), .rsp_data(d1RspData),
        .rsp_id(d1RspId), .rsp_op(d1RspOp), .rsp_on(d1RspOn),
        .busy(d1Busy), .ovf_cnt(d1Ovf)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Exact signed difference in plain integers, then wrapped and clamped views
    function automatic void expResult(input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] wrap, output logic [15:0] sat,
                                      output logic op, output logic on);
        int diff;
        diff = int'($signed(a)) - int'($signed(b));
        wrap = diff[15:0];
        op   = (diff > 32767);
        on   = (diff < -32768);
        sat  = op ? 16'h7FFF : (on ? 16'h8000 : wrap);
    endfunction

    // What the outputs must be now, from the in-flight list and current inputs
    function automatic pred_t predict();
        pred_t       p;
        logic        canAccept;
        logic        g0;
        logic        g1;
        logic [15:0] w;
        logic [15:0] s;
        logic        op;
        logic        on;
        p = '{default: '0};
        canAccept = !rst && ((mq.size() < 2) || rspReady);
        g0 = req0Valid && (!req1Valid || lastGrant);
        g1 = req1Valid && (!req0Valid || !lastGrant);
        p.r0 = canAccept && g0;
        p.r1 = canAccept && g1;
        if (!rst) begin
            p.busy = (mq.size() > 0);
            p.ovf  = 8'(ovfModel);
            if (mq.size() > 0 && mq[0].inB) begin
                expResult(mq[0].a, mq[0].b, w, s, op, on);
                p.v     = 1'b1;
                p.dWrap = w;
                p.dSat  = s;
                p.op    = op;
                p.on    = on;
                p.id    = mq[0].id;
            end
        end
        return p;
    endfunction

    // Advance the model across one rising edge using the inputs held there
    task automatic modelStep();
        pred_t  p;
        entry_t e;
        p = predict();
        if (rst) begin
            mq.delete();
            lastGrant = 1'b1;
            ovfModel  = 0;
            modelOn   = 1'b1;
        end else if (modelOn) begin
            if (p.v && rspReady) begin
                if ((p.op || p.on) && ovfModel < 255) ovfModel++;
                void'(mq.pop_front());
            end
            if (mq.size() > 0) begin
                e = mq[0];
                e.inB = 1'b1;
                mq[0] = e;
            end
            if (p.r0 && req0Valid) begin
                e = '{req0A, req0B, 1'b0, 1'b0};
                mq.push_back(e);
                lastGrant = 1'b0;
            end else if (p.r1 && req1Valid) begin
                e = '{req1A, req1B, 1'b1, 1'b0};
                mq.push_back(e);
                lastGrant = 1'b1;
            end
        end
    endtask

    task automatic checkInst(input string tag, input pred_t p, input logic [15:0] expData,
                             input logic r0, input logic r1, input logic v, input logic bsy,
                             input logic [15:0] data, input logic id, input logic op,
                             input logic on, input logic [7:0] ovf);
        checkOutput({tag, ".req0_ready"}, 32'(r0), 32'(p.r0));
        checkOutput({tag, ".req1_ready"}, 32'(r1), 32'(p.r1));
        checkOutput({tag, ".rsp_valid"}, 32'(v), 32'(p.v));
        checkOutput({tag, ".busy"}, 32'(bsy), 32'(p.busy));
        checkOutput({tag, ".ovf_cnt"}, 32'(ovf), 32'(p.ovf));
        if (p.v) begin
            checkOutput({tag, ".rsp_data"}, 32'(data), 32'(expData));
            checkOutput({tag, ".rsp_id"}, 32'(id), 32'(p.id));
            checkOutput({tag, ".rsp_op"}, 32'(op), 32'(p.op));
            checkOutput({tag, ".rsp_on"}, 32'(on), 32'(p.on));
        end
    endtask

    // Every falling edge, compare both instances against the model
    always @(negedge clk) begin
        pred_t p;
        if (modelOn) begin
            p = predict();
            checkInst("sat0", p, p.dWrap, d0Ready0, d0Ready1, d0RspValid, d0Busy,
                      d0RspData, d0RspId, d0RspOp, d0RspOn, d0Ovf);
            checkInst("sat1", p, p.dSat, d1Ready0, d1Ready1, d1RspValid, d1Busy,
                      d1RspData, d1RspId, d1RspOp, d1RspOn, d1Ovf);
        end
    end

    task automatic applyStimulus(input logic r, input logic v0, input logic [15:0] a0,
                                 input logic [15:0] b0, input logic v1, input logic [15:0] a1,
                                 input logic [15:0] b1, input logic rr);
        @(posedge clk);
        modelStep();
        #2;
        rst       = r;
        req0Valid = v0;
        req0A     = a0;
        req0B     = b0;
        req1Valid = v1;
        req1A     = a1;
        req1B     = b1;
        rspReady  = rr;
    endtask

    task automatic idle(input logic rr);
        applyStimulus(1'b0, 1'b0, Z, Z, 1'b0, Z, Z, rr);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, Z, Z, 1'b0, Z, Z, 1'b0);
        applyStimulus(1'b1, 1'b0, Z, Z, 1'b0, Z, Z, 1'b0);
        applyStimulus(1'b0, 1'b0, Z, Z, 1'b0, Z, Z, 1'b1);
    endtask

    function automatic logic [15:0] pickOperand();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0001;
            default: return r[15:0];
        endcase
    endfunction

    int expGrant[6] = '{0, 1, 0, 1, 0, 1};
    int expRspId[6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        int hsCount;
        logic r, v0, v1, rr;
        rst = 1'b1;
        req0Valid = 1'b0; req1Valid = 1'b0; rspReady = 1'b0;
        req0A = Z; req0B = Z; req1A = Z; req1B = Z;

        $display("[TB] reset state");
        doReset();
        #2;
        checkOutput("reset.rsp_valid", 32'(d0RspValid), 32'd0);
        checkOutput("reset.busy", 32'(d0Busy), 32'd0);
        checkOutput("reset.ovf_cnt", 32'(d1Ovf), 32'd0);

        $display("[TB] single request 100-30");
        applyStimulus(1'b0, 1'b1, 16'd100, 16'd30, 1'b0, Z, Z, 1'b1);
        idle(1'b1);
        #2;
        checkOutput("single.early_valid", 32'(d0RspValid), 32'd0);
        idle(1'b1);
        #2;
        checkOutput("single.rsp_valid", 32'(d0RspValid), 32'd1);
        checkOutput("single.rsp_data", 32'(d0RspData), 32'd70);
        checkOutput("single.rsp_id", 32'(d0RspId), 32'd0);
        checkOutput("single.flags", 32'({d0RspOp, d0RspOn}), 32'd0);
        checkOutput("single.sat_data", 32'(d1RspData), 32'd70);

        $display("[TB] positive overflow");
        doReset();
        applyStimulus(1'b0, 1'b0, Z, Z, 1'b1, 16'h7FFF, 16'hFFFF, 1'b1);
        idle(1'b1);
        idle(1'b1);
        #2;
        checkOutput("povf.wrap_data", 32'(d0RspData), 32'h8000);
        checkOutput("povf.wrap_op", 32'(d0RspOp), 32'd1);
        checkOutput("povf.rsp_id", 32'(d0RspId), 32'd1);
        checkOutput("povf.sat_data", 32'(d1RspData), 32'h7FFF);
        checkOutput("povf.sat_op", 32'(d1RspOp), 32'd1);
        idle(1'b1);
        #2;
        checkOutput("povf.ovf_cnt0", 32'(d0Ovf), 32'd1);
        checkOutput("povf.ovf_cnt1", 32'(d1Ovf), 32'd1);

        $display("[TB] negative overflow");
        applyStimulus(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b0, Z, Z, 1'b1);
        idle(1'b1);
        idle(1'b1);
        #2;
        checkOutput("novf.sat_data", 32'(d1RspData), 32'h8000);
        checkOutput("novf.sat_on", 32'(d1RspOn), 32'd1);
        checkOutput("novf.sat_op", 32'(d1RspOp), 32'd0);
        checkOutput("novf.wrap_data", 32'(d0RspData), 32'h7FFF);
        idle(1'b1);

        $display("[TB] contention");
        doReset();
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b0, j < 6, 16'(j * 10), 16'd1, j < 6, 16'(j * 10 + 5), 16'd2, 1'b1);
            #2;
            if (j < 6) begin
                checkOutput("contend.ready1", 32'(d0Ready1), 32'(expGrant[j]));
                checkOutput("contend.ready0", 32'(d0Ready0), 32'(1 - expGrant[j]));
            end
            if (j >= 2) begin
                checkOutput("contend.rsp_valid", 32'(d0RspValid), 32'd1);
                checkOutput("contend.rsp_id", 32'(d0RspId), 32'(expRspId[j - 2]));
            end
        end
        idle(1'b1);

        $display("[TB] backpressure");
        doReset();
        hsCount = 0;
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b0, 1'b1, 16'd1000, 16'd1, 1'b1, 16'd2000, 16'd2, 1'b0);
            #2;
            if (d0Ready0 || d0Ready1) hsCount++;
            if (j >= 2) begin
                checkOutput("bp.held_data", 32'(d0RspData), 32'd999);
                checkOutput("bp.held_id", 32'(d0RspId), 32'd0);
            end
        end
        checkOutput("bp.absorbed", 32'(hsCount), 32'd2);
        checkOutput("bp.ready0_low", 32'(d0Ready0), 32'd0);
        checkOutput("bp.ready1_low", 32'(d0Ready1), 32'd0);
        idle(1'b1);
        #2;
        checkOutput("bp.drain1_data", 32'(d0RspData), 32'd999);
        idle(1'b1);
        #2;
        checkOutput("bp.drain2_data", 32'(d0RspData), 32'd1998);
        checkOutput("bp.drain2_id", 32'(d0RspId), 32'd1);
        idle(1'b1);
        #2;
        checkOutput("bp.drained", 32'(d0RspValid), 32'd0);

        $display("[TB] reset mid-flight");
        doReset();
        applyStimulus(1'b0, 1'b1, 16'h7FFF, 16'hFFFF, 1'b0, Z, Z, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        #2;
        checkOutput("midrst.ovf_before", 32'(d0Ovf), 32'd1);
        applyStimulus(1'b0, 1'b1, 16'd10, 16'd1, 1'b1, 16'd20, 16'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'd10, 16'd1, 1'b1, 16'd20, 16'd2, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'd10, 16'd1, 1'b1, 16'd20, 16'd2, 1'b0);
        #1;
        checkOutput("midrst.rsp_valid", 32'(d0RspValid), 32'd0);
        checkOutput("midrst.busy", 32'(d0Busy), 32'd0);
        checkOutput("midrst.ovf_cnt", 32'(d0Ovf), 32'd0);
        checkOutput("midrst.ready0", 32'(d0Ready0), 32'd0);
        checkOutput("midrst.ready1", 32'(d1Ready1), 32'd0);
        applyStimulus(1'b0, 1'b1, 16'd10, 16'd1, 1'b1, 16'd20, 16'd2, 1'b1);
        #2;
        checkOutput("midrst.first_tie0", 32'(d0Ready0), 32'd1);
        checkOutput("midrst.first_tie1", 32'(d0Ready1), 32'd0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] overflow counter saturation");
        for (int j = 0; j < 300; j++) begin
            applyStimulus(1'b0, 1'b1, 16'h7FFF, 16'hFFFF, 1'b0, Z, Z, 1'b1);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        #2;
        checkOutput("sat.ovf_cnt0", 32'(d0Ovf), 32'd255);
        checkOutput("sat.ovf_cnt1", 32'(d1Ovf), 32'd255);

        $display("[TB] randomized traffic");
        doReset();
        for (int j = 0; j < 3000; j++) begin
            r  = ($urandom_range(0, 399) == 0);
            v0 = ($urandom_range(0, 9) < 7);
            v1 = ($urandom_range(0, 9) < 6);
            rr = ($urandom_range(0, 9) < 7);
            applyStimulus(r, v0, pickOperand(), pickOperand(), v1, pickOperand(), pickOperand(), rr);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
